// File: rtl/alu_arb_pkg.sv
// Shared widths, requester count and FSM encoding for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned W    = 16;
  localparam int unsigned OPW  = 4;
  localparam int unsigned NREQ = 2;

  // Opcode of the external ALU used for additions.
  localparam logic [OPW-1:0] OP_ADD = OPW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin picker: a lone request always wins; on a tie the
// requester that was not served last wins.
module rr_pick_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Tie-break on the last-served index, otherwise pass the request through.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU. One
// operation is in flight at a time: IDLE accepts, EXEC samples the ALU,
// RESP holds the result until the owner takes it.
module alu_arbiter #(
  parameter int unsigned W   = 16,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_vld,
  output logic [1:0]     req_rdy,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_b1,
  input  logic           req_neg1_0,
  input  logic           req_neg1_1,
  input  logic           req_neg2_0,
  input  logic           req_neg2_1,
  output logic [1:0]     rsp_vld,
  input  logic [1:0]     rsp_rdy,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_cout,
  output logic           rsp_zero,
  output logic           rsp_gzero,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  output logic [OPW-1:0] alu_op,
  output logic           alu_neg1,
  output logic           alu_neg2,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_cout,
  input  logic           alu_zero,
  input  logic           alu_gzero
);

  import alu_arb_pkg::*;

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     gnt;
  logic           accept_c;
  logic           owner_q;
  logic           last_q;
  logic [OPW-1:0] op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           neg1_q;
  logic           neg2_q;

  rr_pick_2 u_pick (
    .req  (req_vld),
    .last (last_q),
    .gnt  (gnt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; ready/valid are decoded from state so
  // the requester sees them in the same cycle the state is entered.
  always_comb begin
    state_d  = state_q;
    req_rdy  = 2'b00;
    rsp_vld  = 2'b00;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_rdy = rst_n ? gnt : 2'b00;
        if (|gnt) begin
          accept_c = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_vld[owner_q] = 1'b1;
        if (rsp_rdy[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request latch and round-robin pointer; last starts at 1 so requester 0
  // is preferred after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
    end else if (accept_c) begin
      owner_q <= gnt[1];
      last_q  <= gnt[1];
      op_q    <= gnt[1] ? req_op1    : req_op0;
      a_q     <= gnt[1] ? req_a1     : req_a0;
      b_q     <= gnt[1] ? req_b1     : req_b0;
      neg1_q  <= gnt[1] ? req_neg1_1 : req_neg1_0;
      neg2_q  <= gnt[1] ? req_neg2_1 : req_neg2_0;
    end
  end

  // Result capture at the end of EXEC; held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_gzero <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_data  <= alu_out;
      rsp_cout  <= alu_cout;
      rsp_zero  <= alu_zero;
      rsp_gzero <= alu_gzero;
    end
  end

  // ALU inputs come straight from the latch so they never follow requester inputs.
  assign alu_in1  = a_q;
  assign alu_in2  = b_q;
  assign alu_op   = op_q;
  assign alu_neg1 = neg1_q;
  assign alu_neg2 = neg2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU closes the loop, and a
// transaction-level model predicts handshakes and results each cycle.
module tb_alu_arbiter;

  import alu_arb_pkg::*;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_vld;
  logic [1:0]     req_rdy;
  logic [OPW-1:0] req_op0, req_op1;
  logic [W-1:0]   req_a0, req_a1, req_b0, req_b1;
  logic           req_neg1_0, req_neg1_1, req_neg2_0, req_neg2_1;
  logic [1:0]     rsp_vld;
  logic [1:0]     rsp_rdy;
  logic [W-1:0]   rsp_data;
  logic           rsp_cout, rsp_zero, rsp_gzero;
  logic [W-1:0]   alu_in1, alu_in2;
  logic [OPW-1:0] alu_op;
  logic           alu_neg1, alu_neg2;
  logic [W-1:0]   alu_out;
  logic           alu_cout, alu_zero, alu_gzero;

  int checks = 0;
  int passes = 0;

  // Model state: one transaction in flight, aged in cycles since accept.
  bit             m_known = 0;
  bit             m_busy  = 0;
  int             m_age   = 0;
  int             m_own   = 0;
  int             m_pref  = 0;
  logic [OPW-1:0] m_op;
  logic [W-1:0]   m_a, m_b;
  logic           m_n1, m_n2;
  logic [W+2:0]   m_exp;

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_neg1_0(req_neg1_0), .req_neg1_1(req_neg1_1),
    .req_neg2_0(req_neg2_0), .req_neg2_1(req_neg2_1),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_gzero(rsp_gzero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_neg1(alu_neg1), .alu_neg2(alu_neg2),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_gzero(alu_gzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {gzero, zero, cout, result}.
  function automatic logic [W+2:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic n1, input logic n2);
    logic [W-1:0] x, y, r;
    logic [W:0]   s;
    x = n1 ? W'(0) - a : a;
    y = n2 ? W'(0) - b : b;
    case (op)
      4'h0:    s = {1'b0, x} + {1'b0, y};
      4'h1:    s = {1'b0, x} - {1'b0, y};
      4'h2:    s = {1'b0, x & y};
      4'h3:    s = {1'b0, x | y};
      4'h4:    s = {1'b0, x ^ y};
      default: s = {1'b0, x};
    endcase
    r = s[W-1:0];
    return {(!r[W-1] && r != 0), (r == 0), s[W], r};
  endfunction

  always_comb {alu_gzero, alu_zero, alu_cout, alu_out} = alu_f(alu_op, alu_in1, alu_in2, alu_neg1, alu_neg2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance the model.
  task automatic cyc(input logic rst, input logic [1:0] vld, input logic [1:0] rr);
    int w;
    logic [1:0] exp_rdy, exp_vld;
    rst_n = rst; req_vld = vld; rsp_rdy = rr;
    #4;
    w = -1;
    if (!m_busy) begin
      if (vld == 2'b11) w = m_pref;
      else if (vld == 2'b01) w = 0;
      else if (vld == 2'b10) w = 1;
    end
    exp_rdy = (w >= 0 && rst) ? 2'(1 << w) : 2'b00;
    exp_vld = (m_busy && m_age >= 2) ? 2'(1 << m_own) : 2'b00;
    if (m_known) begin
      chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      chk("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
      if (m_busy && m_age == 1) begin
        chk("alu_in1", 32'(alu_in1), 32'(m_a));
        chk("alu_in2", 32'(alu_in2), 32'(m_b));
        chk("alu_op",  32'(alu_op),  32'(m_op));
        chk("alu_neg", 32'({alu_neg1, alu_neg2}), 32'({m_n1, m_n2}));
      end
      if (m_busy && m_age >= 2) begin
        chk("rsp_data",  32'(rsp_data), 32'(m_exp[W-1:0]));
        chk("rsp_flags", 32'({rsp_gzero, rsp_zero, rsp_cout}), 32'(m_exp[W+2:W]));
      end
    end
    if (!rst) begin
      m_known = 1; m_busy = 0; m_pref = 0;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_age = 1; m_own = w; m_pref = 1 - w;
        m_op = w ? req_op1 : req_op0;
        m_a  = w ? req_a1 : req_a0;
        m_b  = w ? req_b1 : req_b0;
        m_n1 = w ? req_neg1_1 : req_neg1_0;
        m_n2 = w ? req_neg2_1 : req_neg2_0;
        m_exp = alu_f(m_op, m_a, m_b, m_n1, m_n2);
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (rr[m_own]) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic n1, input logic n2);
    req_op0 = op; req_a0 = a; req_b0 = b; req_neg1_0 = n1; req_neg2_0 = n2;
  endtask

  task automatic set1(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic n1, input logic n2);
    req_op1 = op; req_a1 = a; req_b1 = b; req_neg1_1 = n1; req_neg2_1 = n2;
  endtask

  initial begin
    set0(OP_ADD, 16'h0, 16'h0, 1'b0, 1'b0);
    set1(OP_ADD, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset, then everything reads zero.
    cyc(1'b0, 2'b11, 2'b00);
    cyc(1'b0, 2'b00, 2'b00);
    chk("reset_data", 32'(rsp_data), 32'h0);
    chk("reset_flags", 32'({rsp_gzero, rsp_zero, rsp_cout}), 32'h0);
    chk("reset_alu", 32'({alu_op, alu_in1, alu_neg1, alu_neg2}), 32'h0);
    chk("reset_in2", 32'(alu_in2), 32'h0);

    // Single request: 3 + 4.
    set0(OP_ADD, 16'h0003, 16'h0004, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 2'b00);
    chk("single_exec_in1", 32'(alu_in1), 32'h3);
    cyc(1'b1, 2'b00, 2'b00);
    chk("single_data", 32'(rsp_data), 32'h7);
    chk("single_zero", 32'(rsp_zero), 32'h0);
    cyc(1'b1, 2'b00, 2'b01);

    // Zero flag: -5 + 5.
    set0(OP_ADD, 16'h0005, 16'h0005, 1'b1, 1'b0);
    cyc(1'b1, 2'b01, 2'b00);
    cyc(1'b1, 2'b00, 2'b00);
    chk("zflag_data", 32'(rsp_data), 32'h0);
    chk("zflag_zero", 32'(rsp_zero), 32'h1);
    cyc(1'b1, 2'b00, 2'b01);

    // Backpressure on requester 1 while requester 0 keeps asking.
    set1(4'h1, 16'h0010, 16'h0003, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 2'b00);
    cyc(1'b1, 2'b11, 2'b00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b11, 2'b01);
    cyc(1'b1, 2'b00, 2'b10);
    cyc(1'b1, 2'b00, 2'b00);

    // Non-owner acknowledge is ignored.
    set0(4'h4, 16'hA5A5, 16'h0FF0, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 2'b00);
    cyc(1'b1, 2'b00, 2'b10);
    cyc(1'b1, 2'b00, 2'b10);
    cyc(1'b1, 2'b00, 2'b10);
    cyc(1'b1, 2'b00, 2'b01);

    // Contention: grants alternate.
    for (int i = 0; i < 12; i++) begin
      set0(OP_ADD, W'($urandom), W'($urandom), 1'b0, 1'b0);
      set1(4'h2,   W'($urandom), W'($urandom), 1'b0, 1'b0);
      cyc(1'b1, 2'b11, 2'b11);
    end

    // Reset during RESP owned by requester 1, then requester 0 wins first.
    cyc(1'b1, 2'b00, 2'b11);
    cyc(1'b1, 2'b10, 2'b00);
    cyc(1'b1, 2'b00, 2'b00);
    chk("pre_reset_vld", 32'(rsp_vld), 32'h2);
    cyc(1'b0, 2'b11, 2'b00);
    chk("post_reset_vld", 32'(rsp_vld), 32'h0);
    cyc(1'b1, 2'b11, 2'b00);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      set0(OPW'($urandom_range(0, 5)), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      set1(OPW'($urandom_range(0, 5)), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      cyc(($urandom_range(0, 49) != 0), 2'($urandom), 2'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
